// File: rtl/shift_register_universal.sv
// Universal N-stage x W-bit shift register with a shift counter and a frame pulse.
// Each stage is its own small register with a 4-way next-value mux. The
// top-level wires each stage to its neighbours and runs the frame counter.

// One stage: hold / take right neighbour / take left neighbour / load.
module sru_stage #(
  parameter int          W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [1:0]   mode,
  input  logic [W-1:0] right_nb,  // value moving down on a right shift
  input  logic [W-1:0] left_nb,   // value moving up on a left shift
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  // Stage register: reset dominates, then the mode selects the next value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RST;
    end else if (enable) begin
      case (mode)
        2'b01:   q <= right_nb;
        2'b10:   q <= left_nb;
        2'b11:   q <= load_val;
        default: q <= q;
      endcase
    end
  end

endmodule

module shift_register_universal #(
  parameter int             N           = 3,
  parameter int             W           = 1,
  parameter logic [N*W-1:0] RESET_VALUE = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [1:0]                           mode,
  input  logic [W-1:0]                         signal_in,
  input  logic [N*W-1:0]                       parallel_in,
  output logic [W-1:0]                         signal_out,
  output logic [W-1:0]                         signal_out_msb,
  output logic [N*W-1:0]                       parallel_out,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] shift_count,
  output logic                                 frame_valid
);

  localparam int          CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] MODE_SR   = 2'b01;
  localparam logic [1:0] MODE_SL   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [N-1:0][W-1:0] stages;
  logic                shift_en;

  assign shift_en       = enable && (mode == MODE_SR || mode == MODE_SL);
  assign parallel_out   = stages;
  assign signal_out     = stages[0];
  assign signal_out_msb = stages[N-1];

  // Stage k takes k+1 on a right shift and k-1 on a left shift; the ends
  // take signal_in, so for N==1 both shifts collapse to loading signal_in.
  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [W-1:0] right_nb;
    logic [W-1:0] left_nb;

    if (k == N - 1) begin : g_top
      assign right_nb = signal_in;
    end else begin : g_mid
      assign right_nb = stages[k+1];
    end

    if (k == 0) begin : g_bot
      assign left_nb = signal_in;
    end else begin : g_up
      assign left_nb = stages[k-1];
    end

    sru_stage #(
      .W   (W),
      .RST (RESET_VALUE[k*W +: W])
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .mode     (mode),
      .right_nb (right_nb),
      .left_nb  (left_nb),
      .load_val (parallel_in[k*W +: W]),
      .q        (stages[k])
    );
  end

  // Frame counter: any enabled shift counts; the N-th wraps and pulses
  // frame_valid alongside the completed frame. A load drops a partial frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_count <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (shift_en) begin
        if (shift_count == LAST) begin
          shift_count <= '0;
          frame_valid <= 1'b1;
        end else begin
          shift_count <= shift_count + 1'b1;
        end
      end else if (enable && mode == MODE_LOAD) begin
        shift_count <= '0;
      end
    end
  end

endmodule
